// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle RV32I sequencer.
//   state_t      FSM states
//   ALU_* / IMM_* / WB_* / CAUSE_*   datapath select and trap cause encodings
//   OP_*         RV32I major opcodes
//   ctrl_t       per-instruction control bundle produced by ctrl_decode
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_t;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLL   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_SLT   = 4'd8;
   localparam logic [3:0] ALU_SLTU  = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [2:0] IMM_I   = 3'd0;
   localparam logic [2:0] IMM_ISH = 3'd1;
   localparam logic [2:0] IMM_S   = 3'd2;
   localparam logic [2:0] IMM_B   = 3'd3;
   localparam logic [2:0] IMM_U   = 3'd4;
   localparam logic [2:0] IMM_J   = 3'd5;

   localparam logic [1:0] WB_DMEM = 2'd0;
   localparam logic [1:0] WB_ALU  = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd3;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
   localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      logic [3:0] alu_sel;
      logic [2:0] imm_sel;
      logic [1:0] wb_sel;
      logic       alu_a_sel;
      logic       alu_b_sel;
      logic       branch_signed;
      logic       is_branch;
      logic       is_load;
      logic       is_store;
      logic       is_jump;
      logic [2:0] funct3;
   } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I decoder.
//   instr   in  32  instruction word
//   ctrl    out     control bundle (ctrl_t)
//   illegal out  1  instruction not supported / malformed
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       f7_ok;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[31:25];
   assign unused_bits = ^{instr[24:15], instr[11:7]};

   // funct7 = 0x20 is only meaningful as the sub / sra selector
   assign f7_ok = (funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));

   function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   always_comb begin
      ctrl        = '0;
      ctrl.funct3 = funct3;
      ctrl.wb_sel = WB_ALU;
      illegal     = 1'b0;
      case (opcode)
         OP_REG: begin
            ctrl.alu_sel = alu_op(funct3, funct7[5]);
            illegal      = !f7_ok;
         end
         OP_IMM: begin
            ctrl.alu_b_sel = 1'b1;
            if ((funct3 == 3'd1) || (funct3 == 3'd5)) begin
               ctrl.imm_sel = IMM_ISH;
               ctrl.alu_sel = alu_op(funct3, funct7[5]);
               illegal      = !f7_ok;
            end else begin
               // upper immediate bits are data here, never a sub selector
               ctrl.alu_sel = alu_op(funct3, 1'b0);
            end
         end
         OP_LOAD: begin
            ctrl.alu_b_sel = 1'b1;
            ctrl.wb_sel    = WB_DMEM;
            ctrl.is_load   = 1'b1;
            illegal        = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
         end
         OP_STORE: begin
            ctrl.alu_b_sel = 1'b1;
            ctrl.imm_sel   = IMM_S;
            ctrl.is_store  = 1'b1;
            illegal        = (funct3 > 3'd2);
         end
         OP_BRANCH: begin
            ctrl.alu_a_sel     = 1'b1;
            ctrl.alu_b_sel     = 1'b1;
            ctrl.imm_sel       = IMM_B;
            ctrl.is_branch     = 1'b1;
            ctrl.branch_signed = (funct3 == 3'd4) || (funct3 == 3'd5);
            illegal            = (funct3 == 3'd2) || (funct3 == 3'd3);
         end
         OP_JAL: begin
            ctrl.alu_a_sel = 1'b1;
            ctrl.alu_b_sel = 1'b1;
            ctrl.imm_sel   = IMM_J;
            ctrl.wb_sel    = WB_PC4;
            ctrl.is_jump   = 1'b1;
         end
         OP_JALR: begin
            ctrl.alu_b_sel = 1'b1;
            ctrl.imm_sel   = IMM_I;
            ctrl.wb_sel    = WB_PC4;
            ctrl.is_jump   = 1'b1;
            illegal        = (funct3 != 3'd0);
         end
         OP_AUIPC: begin
            ctrl.alu_a_sel = 1'b1;
            ctrl.alu_b_sel = 1'b1;
            ctrl.imm_sel   = IMM_U;
         end
         OP_LUI: begin
            ctrl.alu_b_sel = 1'b1;
            ctrl.imm_sel   = IMM_U;
            ctrl.alu_sel   = ALU_PASSB;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I core.
//   clk, rst                   clock, async active-high reset
//   instr, br_eq, br_lt        IR contents and comparator results
//   imem_ready, dmem_ready     memory handshakes
//   imem_req, dmem_req/_we     memory requests (held until ready)
//   ir_we, pc_we, pc_sel, reg_wen   single-cycle datapath enables
//   imm_sel .. funct3          registered control bundle, stable EXEC..WB
//   trap, trap_cause           sticky fault and its cause
//
// state  | meaning
// FETCH  | imem request, IR load on ready
// DECODE | decode IR, latch control bundle or trap on illegal
// EXEC   | ALU op; branches resolve and update PC here
// MEM    | data access, stores finish here
// WB     | register write and PC update
// TRAP   | sticky fault, left only by reset
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TO_W        = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        br_eq,
   input  logic        br_lt,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        reg_wen,
   output logic [2:0]  imm_sel,
   output logic        branch_signed,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic [3:0]  alu_sel,
   output logic [1:0]  wb_sel,
   output logic [2:0]  funct3,
   output logic        trap,
   output logic [1:0]  trap_cause
);

   state_t          state_q, state_d;
   ctrl_t           ctrl_q, ctrl_d, dec_ctrl;
   logic            dec_illegal;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [1:0]      cause_q, cause_d;
   logic            timed_out;
   logic            br_taken;

   ctrl_decode u_decode (
      .instr   (instr),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

   // this cycle would be wait number MEM_TIMEOUT; ready still wins over it
   assign timed_out = (MEM_TIMEOUT != 0) && ((32'(to_cnt_q) + 32'd1) == MEM_TIMEOUT);

   // funct3[2] picks lt vs eq, funct3[0] inverts (bne/bge/bgeu)
   assign br_taken = (ctrl_q.funct3[2] ? br_lt : br_eq) ^ ctrl_q.funct3[0];

   assign imm_sel       = ctrl_q.imm_sel;
   assign branch_signed = ctrl_q.branch_signed;
   assign alu_a_sel     = ctrl_q.alu_a_sel;
   assign alu_b_sel     = ctrl_q.alu_b_sel;
   assign alu_sel       = ctrl_q.alu_sel;
   assign wb_sel        = ctrl_q.wb_sel;
   assign funct3        = ctrl_q.funct3;
   assign trap_cause    = cause_q;

   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      cause_d  = cause_q;
      to_cnt_d = '0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      reg_wen  = 1'b0;
      trap     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end else if (timed_out) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_IMEM_TO;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_DECODE: begin
            if (dec_illegal) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               ctrl_d  = dec_ctrl;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (ctrl_q.is_branch) begin
               pc_we   = 1'b1;
               pc_sel  = br_taken;
               state_d = ST_FETCH;
            end else if (ctrl_q.is_load || ctrl_q.is_store) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = ctrl_q.is_store;
            if (dmem_ready) begin
               if (ctrl_q.is_store) begin
                  pc_we   = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (timed_out) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_DMEM_TO;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_WB: begin
            reg_wen = 1'b1;
            pc_we   = 1'b1;
            pc_sel  = ctrl_q.is_jump;
            state_d = ST_FETCH;
         end
         ST_TRAP: trap = 1'b1;
         default: state_d = ST_FETCH;
      endcase
      // requests drop the moment reset asserts, not at the next edge
      if (rst) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
         ir_we    = 1'b0;
         pc_we    = 1'b0;
         pc_sel   = 1'b0;
         reg_wen  = 1'b0;
         trap     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_FETCH;
         ctrl_q   <= '0;
         to_cnt_q <= '0;
         cause_q  <= CAUSE_NONE;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         to_cnt_q <= to_cnt_d;
         cause_q  <= cause_d;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. Each test pushes
// per-cycle stimulus plus expected outputs, then pops and compares cycle by cycle.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        br_eq = 1'b0, br_lt = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_wen;
   logic [2:0]  imm_sel;
   logic        branch_signed, alu_a_sel, alu_b_sel;
   logic [3:0]  alu_sel;
   logic [1:0]  wb_sel;
   logic [2:0]  funct3;
   logic        trap;
   logic [1:0]  trap_cause;

   multicycle_ctrl #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
      .clk(clk), .rst(rst), .instr(instr), .br_eq(br_eq), .br_lt(br_lt),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_wen(reg_wen),
      .imm_sel(imm_sel), .branch_signed(branch_signed),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_sel(alu_sel),
      .wb_sel(wb_sel), .funct3(funct3), .trap(trap), .trap_cause(trap_cause)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   localparam logic [9:0] C_IREQ  = 10'h200;
   localparam logic [9:0] C_DREQ  = 10'h100;
   localparam logic [9:0] C_DWE   = 10'h080;
   localparam logic [9:0] C_IRWE  = 10'h040;
   localparam logic [9:0] C_PCWE  = 10'h020;
   localparam logic [9:0] C_PCSEL = 10'h010;
   localparam logic [9:0] C_REGW  = 10'h008;
   localparam logic [9:0] C_TRAP  = 10'h004;
   localparam logic [9:0] C_FET   = C_IREQ | C_IRWE;

   localparam logic [14:0] M_F3  = 15'h7000;
   localparam logic [14:0] M_ALU = 15'h0F00;
   localparam logic [14:0] M_IMM = 15'h00E0;
   localparam logic [14:0] M_WB  = 15'h0018;
   localparam logic [14:0] M_BS  = 15'h0004;
   localparam logic [14:0] M_A   = 15'h0002;
   localparam logic [14:0] M_B   = 15'h0001;
   localparam logic [14:0] M_ALL = 15'h7FFF;

   typedef struct packed {
      logic        imr, dmr, eq, lt, rs;
      logic [9:0]  ctl;
      logic [14:0] dmask, dexp;
   } step_t;

   step_t sb[$];

   function automatic step_t stp(input logic imr, dmr, eq, lt, rs, input logic [9:0] ctl,
                                 input logic [14:0] dm, de);
      step_t s;
      s.imr = imr; s.dmr = dmr; s.eq = eq; s.lt = lt; s.rs = rs;
      s.ctl = ctl; s.dmask = dm; s.dexp = de;
      return s;
   endfunction

   function automatic logic [14:0] dpv(input logic [2:0] f3, input logic [3:0] alu,
                                       input logic [2:0] imm, input logic [1:0] wb,
                                       input logic bs, a, b);
      return {f3, alu, imm, wb, bs, a, b};
   endfunction

   function automatic logic [9:0] ctl_obs();
      return {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_wen, trap, trap_cause};
   endfunction

   function automatic logic [14:0] dp_obs();
      return {funct3, alu_sel, imm_sel, wb_sel, branch_signed, alu_a_sel, alu_b_sel};
   endfunction

   task automatic apply_reset(input logic [31:0] ins);
      rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; br_eq = 1'b0; br_lt = 1'b0;
      instr = ins;
      cyc = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic drive(input step_t s);
      rst = s.rs; imem_ready = s.imr; dmem_ready = s.dmr; br_eq = s.eq; br_lt = s.lt;
   endtask

   // ---------------------------------------------------------------
   task automatic test_reset();
      step_t s;
      apply_reset(32'h00208133);
      sb.push_back(stp(1, 1, 1, 1, 1, 10'h0, M_ALL, 15'h0));
      sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
      sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
      while (sb.size() != 0) begin
         s = sb.pop_front(); drive(s); #1; cyc++;
         n_checks++;
         if (ctl_obs() !== s.ctl) begin
            n_err++; $display("FAIL reset ctl cyc=%0d got=%b exp=%b", cyc, ctl_obs(), s.ctl);
         end
         if (s.dmask != 15'h0) begin
            n_checks++;
            if ((dp_obs() & s.dmask) !== (s.dexp & s.dmask)) begin
               n_err++; $display("FAIL reset dp cyc=%0d got=%h exp=%h", cyc, dp_obs() & s.dmask, s.dexp & s.dmask);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_alu();
      step_t s;
      logic [31:0] ins [4] = '{32'h00208133, 32'h40208133, 32'h4020D093, 32'h008000EF};
      logic [9:0]  wctl[4] = '{C_REGW | C_PCWE, C_REGW | C_PCWE, C_REGW | C_PCWE,
                               C_REGW | C_PCWE | C_PCSEL};
      logic [14:0] msk [4] = '{M_F3 | M_ALU | M_WB | M_A | M_B, M_F3 | M_ALU | M_WB | M_A | M_B,
                               M_F3 | M_ALU | M_IMM | M_WB | M_A | M_B, M_IMM | M_WB | M_A | M_B};
      logic [14:0] exp [4];
      exp[0] = dpv(3'd0, 4'd0, 3'd0, 2'd1, 1'b0, 1'b0, 1'b0);
      exp[1] = dpv(3'd0, 4'd1, 3'd0, 2'd1, 1'b0, 1'b0, 1'b0);
      exp[2] = dpv(3'd5, 4'd7, 3'd1, 2'd1, 1'b0, 1'b0, 1'b1);
      exp[3] = dpv(3'd0, 4'd0, 3'd5, 2'd3, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         apply_reset(ins[i]);
         sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
         sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
         sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
         sb.push_back(stp(1, 0, 0, 0, 0, wctl[i], msk[i], exp[i]));
         sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
         while (sb.size() != 0) begin
            s = sb.pop_front(); drive(s); #1; cyc++;
            n_checks++;
            if (ctl_obs() !== s.ctl) begin
               n_err++; $display("FAIL alu[%0d] ctl cyc=%0d got=%b exp=%b", i, cyc, ctl_obs(), s.ctl);
            end
            if (s.dmask != 15'h0) begin
               n_checks++;
               if ((dp_obs() & s.dmask) !== (s.dexp & s.dmask)) begin
                  n_err++; $display("FAIL alu[%0d] dp cyc=%0d got=%h exp=%h", i, cyc, dp_obs() & s.dmask, s.dexp & s.dmask);
               end
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_load();
      step_t s;
      // three wait states, then a load that never completes
      for (int k = 0; k < 2; k++) begin
         apply_reset(32'h0000A103);
         sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
         sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
         sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
         if (k == 0) begin
            for (int w = 0; w < 3; w++) sb.push_back(stp(1, 0, 0, 0, 0, C_DREQ, 15'h0, 15'h0));
            sb.push_back(stp(1, 1, 0, 0, 0, C_DREQ, 15'h0, 15'h0));
            sb.push_back(stp(1, 0, 0, 0, 0, C_REGW | C_PCWE, M_F3 | M_ALU | M_WB | M_B,
                             dpv(3'd2, 4'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1)));
            sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
         end else begin
            for (int w = 0; w < 15; w++) sb.push_back(stp(1, 0, 0, 0, 0, C_DREQ, 15'h0, 15'h0));
            sb.push_back(stp(1, 0, 0, 0, 0, C_TRAP | 10'd3, 15'h0, 15'h0));
            sb.push_back(stp(1, 1, 0, 0, 0, C_TRAP | 10'd3, 15'h0, 15'h0));
         end
         while (sb.size() != 0) begin
            s = sb.pop_front(); drive(s); #1; cyc++;
            n_checks++;
            if (ctl_obs() !== s.ctl) begin
               n_err++; $display("FAIL load[%0d] ctl cyc=%0d got=%b exp=%b", k, cyc, ctl_obs(), s.ctl);
            end
            if (s.dmask != 15'h0) begin
               n_checks++;
               if ((dp_obs() & s.dmask) !== (s.dexp & s.dmask)) begin
                  n_err++; $display("FAIL load[%0d] dp cyc=%0d got=%h exp=%h", k, cyc, dp_obs() & s.dmask, s.dexp & s.dmask);
               end
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_store();
      step_t s;
      apply_reset(32'h0020A023);
      sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
      sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
      sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
      sb.push_back(stp(1, 1, 0, 0, 0, C_DREQ | C_DWE | C_PCWE, M_F3 | M_ALU | M_IMM | M_B,
                       dpv(3'd2, 4'd0, 3'd2, 2'd0, 1'b0, 1'b0, 1'b1)));
      sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
      while (sb.size() != 0) begin
         s = sb.pop_front(); drive(s); #1; cyc++;
         n_checks++;
         if (ctl_obs() !== s.ctl) begin
            n_err++; $display("FAIL store ctl cyc=%0d got=%b exp=%b", cyc, ctl_obs(), s.ctl);
         end
         if (s.dmask != 15'h0) begin
            n_checks++;
            if ((dp_obs() & s.dmask) !== (s.dexp & s.dmask)) begin
               n_err++; $display("FAIL store dp cyc=%0d got=%h exp=%h", cyc, dp_obs() & s.dmask, s.dexp & s.dmask);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      step_t s;
      logic [31:0] ins [5] = '{32'h00208463, 32'h00208463, 32'h0020C463, 32'h0020F463, 32'h00209463};
      logic        eqv [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        ltv [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic        tkn [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic        sgn [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         apply_reset(ins[i]);
         sb.push_back(stp(1, 0, eqv[i], ltv[i], 0, C_FET, 15'h0, 15'h0));
         sb.push_back(stp(1, 0, eqv[i], ltv[i], 0, 10'h0, 15'h0, 15'h0));
         sb.push_back(stp(1, 0, eqv[i], ltv[i], 0, C_PCWE | (tkn[i] ? C_PCSEL : 10'h0),
                          M_IMM | M_BS | M_A | M_B,
                          dpv(3'd0, 4'd0, 3'd3, 2'd0, sgn[i], 1'b1, 1'b1)));
         sb.push_back(stp(1, 0, eqv[i], ltv[i], 0, C_FET, 15'h0, 15'h0));
         while (sb.size() != 0) begin
            s = sb.pop_front(); drive(s); #1; cyc++;
            n_checks++;
            if (ctl_obs() !== s.ctl) begin
               n_err++; $display("FAIL branch[%0d] ctl cyc=%0d got=%b exp=%b", i, cyc, ctl_obs(), s.ctl);
            end
            if (s.dmask != 15'h0) begin
               n_checks++;
               if ((dp_obs() & s.dmask) !== (s.dexp & s.dmask)) begin
                  n_err++; $display("FAIL branch[%0d] dp cyc=%0d got=%h exp=%h", i, cyc, dp_obs() & s.dmask, s.dexp & s.dmask);
               end
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_lui_trap();
      step_t s;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            apply_reset(32'h123450B7);
            sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
            sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
            sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
            sb.push_back(stp(1, 0, 0, 0, 0, C_REGW | C_PCWE, M_ALU | M_IMM | M_WB | M_B,
                             dpv(3'd0, 4'd10, 3'd4, 2'd1, 1'b0, 1'b0, 1'b1)));
            sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
         end else begin
            apply_reset(32'hFFFFFFFF);
            sb.push_back(stp(1, 1, 1, 1, 0, C_FET, 15'h0, 15'h0));
            sb.push_back(stp(1, 1, 1, 1, 0, 10'h0, 15'h0, 15'h0));
            for (int w = 0; w < 4; w++) sb.push_back(stp(1, 1, 1, 1, 0, C_TRAP | 10'd1, 15'h0, 15'h0));
            sb.push_back(stp(1, 1, 1, 1, 1, 10'h0, 15'h0, 15'h0));
            sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
         end
         while (sb.size() != 0) begin
            s = sb.pop_front(); drive(s); #1; cyc++;
            n_checks++;
            if (ctl_obs() !== s.ctl) begin
               n_err++; $display("FAIL lui_trap[%0d] ctl cyc=%0d got=%b exp=%b", k, cyc, ctl_obs(), s.ctl);
            end
            if (s.dmask != 15'h0) begin
               n_checks++;
               if ((dp_obs() & s.dmask) !== (s.dexp & s.dmask)) begin
                  n_err++; $display("FAIL lui_trap[%0d] dp cyc=%0d got=%h exp=%h", k, cyc, dp_obs() & s.dmask, s.dexp & s.dmask);
               end
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_illegal();
      step_t s;
      logic [31:0] ins [7] = '{32'h40209133, 32'h0000B103, 32'h00001067, 32'h0020B023,
                               32'h0020A463, 32'h40209093, 32'h0000000F};
      for (int i = 0; i < 7; i++) begin
         apply_reset(ins[i]);
         sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
         sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
         sb.push_back(stp(1, 1, 0, 0, 0, C_TRAP | 10'd1, 15'h0, 15'h0));
         sb.push_back(stp(1, 1, 0, 0, 0, C_TRAP | 10'd1, 15'h0, 15'h0));
         while (sb.size() != 0) begin
            s = sb.pop_front(); drive(s); #1; cyc++;
            n_checks++;
            if (ctl_obs() !== s.ctl) begin
               n_err++; $display("FAIL illegal[%0d] ctl cyc=%0d got=%b exp=%b", i, cyc, ctl_obs(), s.ctl);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_timeout();
      step_t s;
      for (int k = 0; k < 2; k++) begin
         apply_reset(32'h00208133);
         if (k == 0) begin
            for (int w = 0; w < 15; w++) sb.push_back(stp(0, 0, 0, 0, 0, C_IREQ, 15'h0, 15'h0));
            sb.push_back(stp(0, 0, 0, 0, 0, C_TRAP | 10'd2, 15'h0, 15'h0));
            sb.push_back(stp(1, 0, 0, 0, 0, C_TRAP | 10'd2, 15'h0, 15'h0));
         end else begin
            for (int w = 0; w < 14; w++) sb.push_back(stp(0, 0, 0, 0, 0, C_IREQ, 15'h0, 15'h0));
            sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
            sb.push_back(stp(0, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
         end
         while (sb.size() != 0) begin
            s = sb.pop_front(); drive(s); #1; cyc++;
            n_checks++;
            if (ctl_obs() !== s.ctl) begin
               n_err++; $display("FAIL timeout[%0d] ctl cyc=%0d got=%b exp=%b", k, cyc, ctl_obs(), s.ctl);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_rst_mid_mem();
      step_t s;
      apply_reset(32'h0020A023);
      sb.push_back(stp(1, 0, 0, 0, 0, C_FET, 15'h0, 15'h0));
      sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
      sb.push_back(stp(1, 0, 0, 0, 0, 10'h0, 15'h0, 15'h0));
      sb.push_back(stp(1, 0, 0, 0, 0, C_DREQ | C_DWE, 15'h0, 15'h0));
      sb.push_back(stp(1, 0, 0, 0, 0, C_DREQ | C_DWE, 15'h0, 15'h0));
      sb.push_back(stp(1, 1, 0, 0, 1, 10'h0, M_ALL, 15'h0));
      sb.push_back(stp(1, 1, 0, 0, 0, C_FET, 15'h0, 15'h0));
      sb.push_back(stp(1, 1, 0, 0, 0, 10'h0, 15'h0, 15'h0));
      while (sb.size() != 0) begin
         s = sb.pop_front(); drive(s); #1; cyc++;
         n_checks++;
         if (ctl_obs() !== s.ctl) begin
            n_err++; $display("FAIL rst_mid_mem ctl cyc=%0d got=%b exp=%b", cyc, ctl_obs(), s.ctl);
         end
         if (s.dmask != 15'h0) begin
            n_checks++;
            if ((dp_obs() & s.dmask) !== (s.dexp & s.dmask)) begin
               n_err++; $display("FAIL rst_mid_mem dp cyc=%0d got=%h exp=%h", cyc, dp_obs() & s.dmask, s.dexp & s.dmask);
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_branch();
      test_lui_trap();
      test_illegal();
      test_timeout();
      test_rst_mid_mem();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
